// File: rtl/frog_pkg.sv
// Shared constants and state encoding for the frog game controller.
package frog_pkg;

    // Game state; the numeric values are visible on o_state.
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Playfield dimensions.
    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;

    // Bus widths.
    localparam int COL_W   = 5;
    localparam int ROW_W   = 4;
    localparam int LEVEL_W = 7;
    localparam int LIVES_W = 2;
    localparam int HOLD_W  = 24;

endpackage

// File: rtl/lane_hit_detect.sv
// Combinational frog-versus-car overlap test across all lanes.
module lane_hit_detect
    import frog_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int FIRST_LANE_ROW = 1,
    parameter int NUM_COLS       = GRID_COLS
) (
    input  logic [COL_W*NUM_LANES-1:0] car_x,
    input  logic [COL_W-1:0]           frog_x,
    input  logic [ROW_W-1:0]           frog_y,
    output logic                       hit
);

    logic [NUM_LANES-1:0] lane_match;

    // One comparator per lane: the frog must sit on that lane's row and on
    // the car's single column. A car parked off-grid never matches.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int LANE_ROW = FIRST_LANE_ROW + gi;
            logic [COL_W-1:0] lane_col;
            assign lane_col       = car_x[COL_W*gi +: COL_W];
            assign lane_match[gi] = (frog_y == ROW_W'(LANE_ROW)) &&
                                    (frog_x == lane_col) &&
                                    (lane_col < COL_W'(NUM_COLS));
        end
    endgenerate

    assign hit = |lane_match;

endmodule

// File: rtl/frog_game_ctrl.sv
// Game-state controller: collision/goal detection, lives, level, respawn.
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int                NUM_LANES      = 4,
    parameter int                FIRST_LANE_ROW = 1,
    parameter int                GRID_COLS      = frog_pkg::GRID_COLS,
    parameter int                INIT_LIVES     = 3,
    parameter int                MAX_LEVEL      = 16,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES    = 24'd12_500_000
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic [COL_W*NUM_LANES-1:0] i_car_x,
    input  logic [COL_W-1:0]           i_frog_x,
    input  logic [ROW_W-1:0]           i_frog_y,
    input  logic                       i_start,
    output logic [LEVEL_W-1:0]         o_level,
    output logic [LIVES_W-1:0]         o_lives,
    output logic [1:0]                 o_state,
    output logic                       o_frog_reset,
    output logic                       o_game_over
);

    localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(INIT_LIVES);
    // Counter is loaded with N-1 so the freeze lasts exactly N cycles.
    localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_CYCLES - HOLD_W'(1);

    state_t              state_reg,      state_next;
    logic [LEVEL_W-1:0]  level_reg,      level_next;
    logic [LIVES_W-1:0]  lives_reg,      lives_next;
    logic [HOLD_W-1:0]   hold_cnt_reg,   hold_cnt_next;
    logic                frog_reset_reg, frog_reset_next;
    logic                game_over_reg,  game_over_next;

    logic car_hit;
    logic at_goal;

    lane_hit_detect #(
        .NUM_LANES      (NUM_LANES),
        .FIRST_LANE_ROW (FIRST_LANE_ROW),
        .NUM_COLS       (GRID_COLS)
    ) u_lane_hit_detect (
        .car_x  (i_car_x),
        .frog_x (i_frog_x),
        .frog_y (i_frog_y),
        .hit    (car_hit)
    );

    // Row 0 is the goal row; no lane can live there.
    assign at_goal = (i_frog_y == '0);

    // Next-state, counter, level and lives update.
    always_comb begin
        state_next      = state_reg;
        level_next      = level_reg;
        lives_next      = lives_reg;
        hold_cnt_next   = hold_cnt_reg;
        frog_reset_next = 1'b0;

        case (state_reg)
            ST_PLAY: begin
                // A collision outranks reaching the goal.
                if (car_hit) begin
                    state_next    = ST_HIT;
                    lives_next    = (lives_reg != '0) ? lives_reg - LIVES_W'(1) : lives_reg;
                    hold_cnt_next = HOLD_LOAD;
                end else if (at_goal) begin
                    state_next    = ST_WIN;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_HIT: begin
                if (hold_cnt_reg == '0) begin
                    if (lives_reg == '0) begin
                        state_next = ST_OVER;
                    end else begin
                        state_next      = ST_PLAY;
                        frog_reset_next = 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
                end
            end
            ST_WIN: begin
                if (hold_cnt_reg == '0) begin
                    level_next      = (level_reg < LEVEL_TOP) ? level_reg + LEVEL_W'(1) : level_reg;
                    state_next      = ST_PLAY;
                    frog_reset_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
                end
            end
            ST_OVER: begin
                if (i_start) begin
                    level_next      = LEVEL_FIRST;
                    lives_next      = LIVES_START;
                    state_next      = ST_PLAY;
                    frog_reset_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_PLAY;
            end
        endcase

        game_over_next = (state_next == ST_OVER);
    end

    // State and output registers; reset also aborts any hold in progress.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg      <= ST_PLAY;
            level_reg      <= LEVEL_FIRST;
            lives_reg      <= LIVES_START;
            hold_cnt_reg   <= '0;
            frog_reset_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            lives_reg      <= lives_next;
            hold_cnt_reg   <= hold_cnt_next;
            frog_reset_reg <= frog_reset_next;
            game_over_reg  <= game_over_next;
        end
    end

    assign o_state      = state_reg;
    assign o_level      = level_reg;
    assign o_lives      = lives_reg;
    assign o_frog_reset = frog_reset_reg;
    assign o_game_over  = game_over_reg;

endmodule
